// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding and default tuning for the pong game blocks.
package pong_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
  localparam int HITS_PER_LEVEL_DEF = 4;
  localparam int MAX_LEVEL_DEF = 99;
endpackage

// File: rtl/bcd_inc2.sv
// bcd_inc2: combinational two-digit BCD incrementer; holds its input when sat is high.
module bcd_inc2 (
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       sat,
  output logic [3:0] tens_n,
  output logic [3:0] ones_n
);
  logic wrap;
  always_comb begin
    wrap   = ones == 4'd9;
    ones_n = sat ? ones : (wrap ? 4'd0 : ones + 4'd1);
    tens_n = sat ? tens : (wrap ? (tens == 4'd9 ? 4'd0 : tens + 4'd1) : tens);
  end
endmodule

// File: rtl/level_tracker.sv
// level_tracker: counts paddle hits into a saturating game level with BCD digits
// and a sticky redraw request for the digit plotter.
module level_tracker
  import pong_pkg::*;
#(
  parameter int HITS_PER_LEVEL = HITS_PER_LEVEL_DEF,
  parameter int MAX_LEVEL = MAX_LEVEL_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       hit,
  input  logic       gameOver,
  input  logic       redrawAck,
  output logic [6:0] level,
  output logic [3:0] levelTens,
  output logic [3:0] levelOnes,
  output logic       redrawReq,
  output logic       levelUp,
  output logic       playing
);
  localparam logic [3:0] WRAP = 4'(HITS_PER_LEVEL - 1);
  localparam logic [6:0] TOP = 7'(MAX_LEVEL);
  state_t state;
  logic [3:0] cnt, tens_n, ones_n;
  logic at_max;
  assign at_max = level == TOP;
  assign playing = state == PLAY;
  bcd_inc2 u_inc (
    .tens(levelTens),
    .ones(levelOnes),
    .sat(at_max),
    .tens_n(tens_n),
    .ones_n(ones_n)
  );
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      level <= '0;
      levelTens <= '0;
      levelOnes <= '0;
      cnt <= '0;
      redrawReq <= 1'b0;
      levelUp <= 1'b0;
    end else begin
      levelUp <= 1'b0;
      if (state == PLAY) begin
        if (gameOver) begin
          state <= OVER;
          if (redrawAck) redrawReq <= 1'b0;
        end else if (hit && cnt == WRAP && !at_max) begin
          // a level change wins over a same-cycle ack so the new value still gets drawn
          cnt <= '0;
          level <= level + 7'd1;
          levelTens <= tens_n;
          levelOnes <= ones_n;
          levelUp <= 1'b1;
          redrawReq <= 1'b1;
        end else begin
          if (hit) cnt <= cnt == WRAP ? 4'd0 : cnt + 4'd1;
          if (redrawAck) redrawReq <= 1'b0;
        end
      end else if (start && !gameOver) begin
        state <= PLAY;
        level <= '0;
        levelTens <= '0;
        levelOnes <= '0;
        cnt <= '0;
        redrawReq <= 1'b1;
      end
    end
endmodule

// File: tb/tb_level_tracker.sv
// tb_level_tracker: directed and random checks of level_tracker against a hit-count model.
module tb_level_tracker;
  localparam int H = 4;
  localparam int MAXL = 99;
  logic clock = 1'b0;
  logic resetn, start, hit, gameOver, redrawAck;
  logic [6:0] level;
  logic [3:0] levelTens, levelOnes;
  logic redrawReq, levelUp, playing;
  int total = 0, bad = 0, ups = 0;
  int mstate, hits, mlevel;
  bit mreq, mup;

  level_tracker #(.HITS_PER_LEVEL(H), .MAX_LEVEL(MAXL)) dut (
    .clock(clock), .resetn(resetn), .start(start), .hit(hit), .gameOver(gameOver),
    .redrawAck(redrawAck), .level(level), .levelTens(levelTens), .levelOnes(levelOnes),
    .redrawReq(redrawReq), .levelUp(levelUp), .playing(playing)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mstate = 0; hits = 0; mlevel = 0; mreq = 0; mup = 0;
  endtask

  task automatic chk_all();
    chk("level", 32'(level), 32'(mlevel));
    chk("tens", 32'(levelTens), 32'(mlevel / 10));
    chk("ones", 32'(levelOnes), 32'(mlevel % 10));
    chk("redrawReq", 32'(redrawReq), 32'(mreq));
    chk("levelUp", 32'(levelUp), 32'(mup));
    chk("playing", 32'(playing), 32'(mstate == 1));
  endtask

  // Level is simply the number of whole hit groups this game, capped at MAXL.
  task automatic step(input bit s, input bit h, input bit g, input bit a);
    int nl;
    start = s; hit = h; gameOver = g; redrawAck = a;
    @(posedge clock);
    mup = 0;
    if (mstate == 1) begin
      if (a) mreq = 0;
      if (g) mstate = 2;
      else if (h) begin
        hits++;
        nl = hits / H > MAXL ? MAXL : hits / H;
        if (nl != mlevel) begin mlevel = nl; mup = 1; mreq = 1; end
      end
    end else if (s && !g) begin
      mstate = 1; hits = 0; mlevel = 0; mreq = 1;
    end
    #1;
    if (levelUp) ups++;
    chk_all();
    start = 0; hit = 0; gameOver = 0; redrawAck = 0;
  endtask

  initial begin
    resetn = 1'b0; start = 0; hit = 0; gameOver = 0; redrawAck = 0;
    model_reset();
    #12 resetn = 1'b1;
    chk_all();
    step(1, 0, 0, 0);
    chk("start_req", 32'(redrawReq), 32'd1);
    step(0, 0, 0, 1);
    ups = 0;
    repeat (4) step(0, 1, 0, 0);
    chk("l1_level", 32'(level), 32'd1);
    chk("l1_ones", 32'(levelOnes), 32'd1);
    chk("l1_ups", 32'(ups), 32'd1);
    chk("l1_req", 32'(redrawReq), 32'd1);
    repeat (36) step(0, 1, 0, 1);
    chk("l10_level", 32'(level), 32'd10);
    chk("l10_tens", 32'(levelTens), 32'd1);
    chk("l10_ones", 32'(levelOnes), 32'd0);
    chk("l10_ups", 32'(ups), 32'd10);
    step(0, 0, 0, 1);
    repeat (8) step(0, 1, 0, 0);
    chk("coal_req", 32'(redrawReq), 32'd1);
    step(0, 0, 0, 1);
    chk("ack_clear", 32'(redrawReq), 32'd0);
    repeat (3) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    chk("ack_change_req", 32'(redrawReq), 32'd1);
    for (int i = 0; i < 2000 && mlevel < MAXL; i++) step(0, 1, 0, 1);
    chk("sat_level", 32'(level), 32'd99);
    step(0, 0, 0, 1);
    ups = 0;
    repeat (4) step(0, 1, 0, 0);
    chk("sat_hold", 32'(level), 32'd99);
    chk("sat_ups", 32'(ups), 32'd0);
    chk("sat_req", 32'(redrawReq), 32'd0);
    step(0, 1, 1, 0);
    chk("over_level", 32'(level), 32'd99);
    step(0, 1, 0, 0);
    chk("over_playing", 32'(playing), 32'd0);
    step(1, 0, 0, 0);
    repeat (20) step(0, 1, 0, 0);
    chk("mid_level", 32'(level), 32'd5);
    #3 resetn = 1'b0;
    #1;
    model_reset();
    chk_all();
    #2 resetn = 1'b1;
    step(1, 0, 0, 0);
    repeat (1500)
      step($urandom % 16 == 0, 1'($urandom % 2), $urandom % 64 == 0, $urandom % 3 == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/level_tracker.md
LEVEL_TRACKER -- requirements
Module: level_tracker

Interface
REQ-001 SHALL have parameter HITS_PER_LEVEL, default 4, meaning paddle hits needed per level increment (range 1..15).
REQ-002 SHALL have parameter MAX_LEVEL, default 99, meaning saturation value of level (range 1..99).
REQ-003 SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse: begin a new game.
REQ-006 SHALL have port hit  in  1  one-cycle pulse: ball struck paddle.
REQ-007 SHALL have port gameOver  in  1  level-sensitive: ball missed; game ended.
REQ-008 SHALL have port redrawAck  in  1  digit plotting stage has accepted the current level.
REQ-009 SHALL have port level  out  7  current level, binary.
REQ-010 SHALL have port levelTens  out  4  tens digit of level, BCD.
REQ-011 SHALL have port levelOnes  out  4  ones digit of level, BCD.
REQ-012 SHALL have port redrawReq  out  1  level changed; plotting stage must redraw digits.
REQ-013 SHALL have port levelUp  out  1  one-cycle pulse on each level increment.
REQ-014 SHALL have port playing  out  1  high while in state PLAY.

Function
REQ-015 SHALL implement FSM states IDLE, PLAY, OVER; IDLE is entered only from reset.
REQ-016 SHALL transition IDLE->PLAY and OVER->PLAY on start=1 when gameOver=0.
REQ-017 SHALL transition PLAY->OVER on gameOver=1; gameOver takes priority over start and hit in the same cycle.
REQ-018 SHALL ignore start while in PLAY, and ignore hit outside PLAY.
REQ-019 SHALL, on entry to PLAY, clear level, levelTens, levelOnes and the hit counter to 0, and set redrawReq.
REQ-020 SHALL, in PLAY on hit=1, increment a hit counter (width 4); when the counter equals HITS_PER_LEVEL-1, wrap it to 0 and increment the level.
REQ-021 SHALL make the updated level, BCD digits and levelUp visible on the cycle after the hit edge (1-cycle latency).
REQ-022 SHALL keep the BCD digits consistent with level: ones digit wraps 9->0 with a tens carry.
REQ-023 SHALL saturate level at MAX_LEVEL; at saturation the hit counter still wraps, but levelUp does not pulse and redrawReq is not set.
REQ-024 SHALL set redrawReq on every change of level, including the clear at game start, and hold it until a cycle in which redrawAck=1 is sampled.
REQ-025 SHALL coalesce changes: when a level change coincides with redrawAck=1, or occurs while redrawReq is already high, redrawReq remains high after that edge.
REQ-026 SHALL hold level, BCD digits and redrawReq unchanged in OVER until the next start.
REQ-027 SHALL drive playing combinationally from the state register; all other outputs SHALL be registered.

Reset
REQ-028 SHALL, on resetn=0 at any time (including mid-handshake), immediately force state IDLE, level=0, levelTens=0, levelOnes=0, hit counter=0, redrawReq=0, levelUp=0, playing=0.
REQ-029 SHALL resume operation on the first rising clock edge after resetn returns high.

Structure
REQ-030 SHALL take the state encoding (IDLE/PLAY/OVER) and the default values of HITS_PER_LEVEL and MAX_LEVEL from shared package pong_pkg.
REQ-031 SHALL instantiate one sub-module, bcd_inc2: a combinational two-digit BCD incrementer with a saturate-at-limit input.

Verification
REQ-032 SHALL cover: reset, then start, then 4 hits (HITS_PER_LEVEL=4) -> level=1, levelOnes=1, levelUp pulses once, redrawReq rises.
REQ-033 SHALL cover: 40 hits -> level=10, levelTens=1, levelOnes=0, exactly 10 levelUp pulses.
REQ-034 SHALL cover: level at 99, then 4 more hits -> level stays 99, no levelUp pulse, redrawReq stays low after the prior ack.
REQ-035 SHALL cover: hit and gameOver in the same cycle -> state OVER, level unchanged; a subsequent hit is ignored.
REQ-036 SHALL cover: redrawAck held low across 2 level changes -> redrawReq stays high; a single ack then clears it; a level change in the same cycle as the ack keeps redrawReq high.
REQ-037 SHALL cover: resetn pulsed low mid-game at level 5 with redrawReq high -> all outputs 0 immediately, without waiting for a clock edge.
